// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants and types for the instruction fetch unit.
// Holds the FSM state encoding, the reset PC and the default cache size.
package ifetch_pkg;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC         = 32'h0000_0000;
    localparam int          ICACHE_LINES_DEF = 64;

    // Instruction addresses are word aligned; low two bits are always zero.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_icache.sv
// ifetch_icache: direct-mapped, one-word-per-line instruction cache.
// Read side is combinational on the word address; every fill writes data,
// tag and valid for the filled word address. Only built with ICACHE_EN.
module ifetch_icache
    import ifetch_pkg::*;
#(
    parameter int LINES = ICACHE_LINES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [29:0] rd_word,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [29:0] wr_word,
    input  logic [31:0] wr_data
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [IDX_W-1:0] rd_idx_s;
    logic [TAG_W-1:0] rd_tag_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [TAG_W-1:0] wr_tag_s;

    assign rd_idx_s = rd_word[IDX_W-1:0];
    assign rd_tag_s = rd_word[29:IDX_W];
    assign wr_idx_s = wr_word[IDX_W-1:0];
    assign wr_tag_s = wr_word[29:IDX_W];

    assign hit     = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
    assign rd_data = data_q[rd_idx_s];

    // Next valid bits: a fill marks its line valid.
    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx_s] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits: cleared by reset, frozen while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (rdy) begin
            valid_q <= valid_d;
        end
    end

    // Tag/data storage: written on fill only; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (!rst && rdy && wr_en) begin
            tag_q[wr_idx_s]  <= wr_tag_s;
            data_q[wr_idx_s] <= wr_data;
        end
    end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit. Fetches one word at a time from memory
// (or from the optional instruction cache) and pushes it with its address
// into the instruction queue. Handles redirects by discarding in-flight data.
// Optional feature: define ICACHE_EN to build the direct-mapped icache.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int ICACHE_LINES = ICACHE_LINES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        full,
    output logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    input  logic        jump_en,
    input  logic [31:0] jump_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        mem_req_q,  mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        inst_rdy_q, inst_rdy_d;
    logic [31:0] inst_q,     inst_d;
    logic [31:0] pc_out_q,   pc_out_d;
    logic        discard_q,  discard_d;

    logic        cache_hit_s;
    logic [31:0] cache_data_s;
    logic [31:0] pc_next_s;
    logic [31:0] jump_tgt_s;

    assign pc_next_s  = pc_q + 32'd4;
    assign jump_tgt_s = align_pc(jump_pc);

`ifdef ICACHE_EN
    logic fill_s;

    // Every completion seen while waiting fills the cache, discarded or not.
    assign fill_s = (state_q == S_WAIT_MEM) && mem_done;

    ifetch_icache #(
        .LINES (ICACHE_LINES)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rdy     (rdy),
        .rd_word (pc_q[31:2]),
        .hit     (cache_hit_s),
        .rd_data (cache_data_s),
        .wr_en   (fill_s),
        .wr_word (mem_addr_q[31:2]),
        .wr_data (mem_data)
    );
`else
    // No cache storage: never hit. The size parameter only matters with the cache.
    assign cache_hit_s  = 1'b0 & (ICACHE_LINES > 0);
    assign cache_data_s = 32'h0000_0000;
`endif

    // Next-state and output logic of the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        inst_rdy_d = 1'b0;
        inst_d     = inst_q;
        pc_out_d   = pc_out_q;
        discard_d  = discard_q;

        case (state_q)
            S_IDLE: begin
                if (jump_en) begin
                    pc_d = jump_tgt_s;
                end else if (full) begin
                    pc_d = pc_q;
                end else if (cache_hit_s) begin
                    inst_d     = cache_data_s;
                    pc_out_d   = pc_q;
                    inst_rdy_d = 1'b1;
                    pc_d       = pc_next_s;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = S_WAIT_MEM;
                end
            end
            S_WAIT_MEM: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = S_IDLE;
                    if (jump_en) begin
                        pc_d = jump_tgt_s;
                    end else if (discard_q) begin
                        pc_d = pc_q;
                    end else begin
                        inst_d     = mem_data;
                        pc_out_d   = pc_q;
                        inst_rdy_d = 1'b1;
                        pc_d       = pc_next_s;
                    end
                end else if (jump_en) begin
                    pc_d      = jump_tgt_s;
                    discard_d = 1'b1;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    // State register: synchronous reset wins over everything; rdy=0 freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0000_0000;
            inst_rdy_q <= 1'b0;
            inst_q     <= 32'h0000_0000;
            pc_out_q   <= 32'h0000_0000;
            discard_q  <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            inst_rdy_q <= inst_rdy_d;
            inst_q     <= inst_d;
            pc_out_q   <= pc_out_d;
            discard_q  <= discard_d;
        end
    end

    assign inst_rdy = inst_rdy_q;
    assign inst     = inst_q;
    assign pc_out   = pc_out_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed self-checking bench for ifetch. The memory controller
// is played by hand in the stimulus sequence; expected values are constants.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        full;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        jump_en;
    logic [31:0] jump_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int checks   = 0;
    int errors   = 0;
    int push_cnt = 0;
    int exp_push = 0;

    ifetch #(.ICACHE_LINES(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .full     (full),
        .inst_rdy (inst_rdy),
        .inst     (inst),
        .pc_out   (pc_out),
        .jump_en  (jump_en),
        .jump_pc  (jump_pc),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_done (mem_done),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Count every push strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (inst_rdy === 1'b1) push_cnt <= push_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse mem_done for one cycle with the given word.
    task automatic fetch_done(input logic [31:0] data);
        mem_done = 1'b1;
        mem_data = data;
        tick();
        mem_done = 1'b0;
        mem_data = 32'h0000_0000;
    endtask

    task automatic expect_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
    endtask

    task automatic expect_push(input string tag, input logic [31:0] data, input logic [31:0] pc);
        chk({tag, "_rdy"}, {31'd0, inst_rdy}, 32'd1);
        chk({tag, "_inst"}, inst, data);
        chk({tag, "_pc"}, pc_out, pc);
        exp_push++;
    endtask

    task automatic expect_no_push(input string tag);
        chk({tag, "_nopush"}, {31'd0, inst_rdy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; full = 1'b0; jump_en = 1'b0;
        jump_pc = 32'h0; mem_done = 1'b0; mem_data = 32'h0;
        tick();
        tick();
        // Reset state
        chk("rst_req",  {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdy",  {31'd0, inst_rdy}, 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc",   pc_out, 32'h0);
        rst = 1'b0;

        // First fetch at 0x0, memory answers in the third cycle
        tick();
        expect_req("f0", 32'h0);
        tick();
        tick();
        expect_req("f0_hold", 32'h0);
        fetch_done(32'h0000_0013);
        expect_push("f0", 32'h0000_0013, 32'h0);
        chk("f0_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        expect_no_push("f0_once");
        expect_req("f1", 32'h4);
        fetch_done(32'h1111_1111);
        expect_push("f1", 32'h1111_1111, 32'h4);
        tick();
        expect_req("f2", 32'h8);

        // Redirect while waiting on 0x8; low target bits are dropped
        jump_en = 1'b1; jump_pc = 32'h0000_1002;
        tick();
        jump_en = 1'b0;
        expect_req("jw_hold", 32'h8);
        expect_no_push("jw");
        tick();
        fetch_done(32'hDEAD_BEEF);
        expect_no_push("jw_discard");
        chk("jw_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        expect_req("jw_tgt", 32'h0000_1000);
        fetch_done(32'hAAAA_0001);
        expect_push("jw_tgt", 32'hAAAA_0001, 32'h0000_1000);
        tick();
        expect_req("f1004", 32'h0000_1004);

        // Redirect to 0x10, then jump coincident with mem_done at 0x10
        jump_en = 1'b1; jump_pc = 32'h10;
        tick();
        jump_en = 1'b0;
        fetch_done(32'h5555_5555);
        expect_no_push("j10_discard");
        tick();
        expect_req("f10", 32'h10);
        jump_en = 1'b1; jump_pc = 32'h200;
        fetch_done(32'h6666_6666);
        jump_en = 1'b0;
        expect_no_push("jc");
        chk("jc_req_drop", {31'd0, mem_req}, 32'd0);
        tick();
        expect_no_push("jc_after");
        expect_req("jc_tgt", 32'h200);

        // rdy low for 5 cycles mid-fetch: everything holds, jump ignored
        rdy = 1'b0; jump_en = 1'b1; jump_pc = 32'h500;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_req("frz", 32'h200);
            expect_no_push("frz");
        end
        rdy = 1'b1; jump_en = 1'b0;
        fetch_done(32'h0000_0022);
        expect_push("frz_done", 32'h0000_0022, 32'h200);
        tick();
        expect_no_push("frz_once");
        expect_req("f204", 32'h204);

        // Reset mid-fetch with full held: stale mem_done ignored, no request
        rst = 1'b1; full = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_req",  {31'd0, mem_req}, 32'd0);
        chk("mrst_addr", mem_addr, 32'h0);
        chk("mrst_pc",   pc_out, 32'h0);
        fetch_done(32'h0000_0099);
        expect_no_push("stale");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_noreq", {31'd0, mem_req}, 32'd0);
            expect_no_push("full");
        end
        full = 1'b0;
        tick();
        expect_req("rf0", 32'h0);
        fetch_done(32'h0000_0013);
        expect_push("rf0", 32'h0000_0013, 32'h0);

        // Fetch 0x4..0xC; full rises during the 0x8 fetch which still pushes
        for (int k = 1; k <= 3; k++) begin
            tick();
            expect_req("seq", 32'(4 * k));
            if (k == 2) full = 1'b1;
            fetch_done(32'hC000_0000 + 32'(k));
            expect_push("seq", 32'hC000_0000 + 32'(k), 32'(4 * k));
            full = 1'b0;
        end
        tick();
        expect_req("f10b", 32'h10);
        jump_en = 1'b1; jump_pc = 32'h0;
        tick();
        jump_en = 1'b0;
        fetch_done(32'h0000_0077);
        expect_no_push("j0_discard");

`ifdef ICACHE_EN
        // Cached replay of 0x0..0xC on consecutive cycles, no memory traffic
        tick();
        chk("hit0_req", {31'd0, mem_req}, 32'd0);
        expect_push("hit0", 32'h0000_0013, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("hit_req", {31'd0, mem_req}, 32'd0);
            expect_push("hit", 32'hC000_0000 + 32'(k), 32'(4 * k));
        end
`else
        // Without the cache the jump back refetches from memory
        tick();
        expect_no_push("nocache");
        expect_req("nocache", 32'h0);
`endif

        tick();
        chk("push_count", 32'(push_cnt), 32'(exp_push));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter ICACHE_LINES, default 64, number of one-word instruction-cache lines (power of two, used only with ICACHE_EN).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global ready; when 0 all registers hold their values.
REQ-005 full  input  1  instruction queue nearly full (asserts with 2 free slots remaining).
REQ-006 inst_rdy  output  1  one-cycle push strobe to instruction queue.
REQ-007 inst  output  32  fetched instruction word, valid with inst_rdy.
REQ-008 pc_out  output  32  address of inst, valid with inst_rdy.
REQ-009 jump_en  input  1  redirect request (branch mispredict or jump).
REQ-010 jump_pc  input  32  redirect target, valid with jump_en.
REQ-011 mem_req  output  1  word-fetch request to memory controller, level, held until mem_done.
REQ-012 mem_addr  output  32  word address of the request, stable while mem_req=1.
REQ-013 mem_done  input  1  one-cycle completion strobe from memory controller.
REQ-014 mem_data  input  32  fetched word, valid with mem_done.

Function
REQ-015 Two-state FSM: IDLE, WAIT_MEM.
REQ-016 IDLE, jump_en=1: pc <= jump_pc, no fetch started, no push that cycle.
REQ-017 IDLE, full=1, jump_en=0: no fetch started, pc unchanged.
REQ-018 IDLE, full=0, jump_en=0, cache miss (or cache absent): mem_req <= 1, mem_addr <= pc, go to WAIT_MEM.
REQ-019 WAIT_MEM, mem_done=1, no pending discard: inst <= mem_data, pc_out <= pc, inst_rdy <= 1 next cycle, pc <= pc+4 (mod 2^32), mem_req <= 0, go to IDLE.
REQ-020 A fetch in flight when full rises still completes and pushes; the 2-slot margin in full absorbs it.
REQ-021 jump_en=1 in WAIT_MEM: pc <= jump_pc, discard flag set; the matching mem_done produces no push, clears the flag, returns to IDLE.
REQ-022 jump_en=1 in the same cycle as mem_done: the returned word is discarded, pc <= jump_pc.
REQ-023 inst_rdy is 0 in every cycle not named in REQ-019/REQ-027; never two pushes for one pc.
REQ-024 pc bits [1:0] are always 00; jump_pc[1:0] is ignored (forced 00).

Reset
REQ-025 On rst: state=IDLE, pc=0, mem_req=0, mem_addr=0, inst_rdy=0, inst=0, pc_out=0, discard flag=0, all cache valid bits=0; rst overrides rdy, jump_en and mem_done, and any in-flight request is abandoned (a later mem_done in IDLE is ignored).

Configuration
REQ-026 Macro ICACHE_EN selects the direct-mapped cache, index pc[log2(ICACHE_LINES)+1:2], tag = remaining upper bits.
REQ-027 With ICACHE_EN: IDLE hit with full=0, jump_en=0 pushes the cached word next cycle (1-cycle latency), pc <= pc+4, no mem_req; every mem_done (including discarded ones) writes data, tag and valid for its mem_addr.
REQ-028 Without ICACHE_EN: no cache storage; every fetch goes through mem_req; minimum latency is 2 cycles plus memory latency.

Structure
REQ-029 FSM state encodings, RESET_PC (0) and ICACHE_LINES default live in shared const.v.
REQ-030 Cache storage and hit logic form one sub-module icache (read by index/tag, written on fill), instantiated only under ICACHE_EN.

Verification
REQ-031 Reset, memory returns 0x00000013 at 0 after 3 cycles -> mem_req=1 addr 0x0; one push inst=0x00000013 pc_out=0x0; next mem_addr=0x4.
REQ-032 full=1 held from reset -> mem_req stays 0, no push; full drops -> request at 0x0.
REQ-033 jump_en with jump_pc=0x1000 while waiting on 0x8 -> 0x8 data not pushed; next request 0x1000, push pc_out=0x1000.
REQ-034 jump_en coincident with mem_done at 0x10 -> no push; next mem_addr = jump target.
REQ-035 ICACHE_EN, jump back to 0x0 after 0x0..0xC fetched -> pushes at 0x0..0xC on consecutive cycles with mem_req=0.
REQ-036 rdy=0 for 5 cycles mid-fetch -> outputs frozen, exactly one push after rdy returns; rst mid-fetch -> pc=0, stale mem_done ignored.
